// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: command sequencer for an external DW x DEPTH LIFO with push/pop/tos strobes.
// Define STACK_SEQ_SWAP_EN to build op 8 (SWAP); otherwise op 8 is rejected as illegal.
module stack_op_sequencer #(
  parameter int DW      = 8,
  parameter int DEPTH   = 32,
  parameter int DEPTH_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [DW-1:0]      cmd_data,
  output logic               done,
  output logic               err,
  output logic [DW-1:0]      res_data,
  output logic [DEPTH_W-1:0] depth,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_tos,
  output logic [DW-1:0]      stk_in,
  input  logic [DW-1:0]      stk_out
);
  localparam logic [3:0] OP_PUSH = 4'd0;
  localparam logic [3:0] OP_POP  = 4'd1;
  localparam logic [3:0] OP_TOS  = 4'd2;
  localparam logic [3:0] OP_DUP  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SWAP = 4'd8;
`ifdef STACK_SEQ_SWAP_EN
  localparam logic [3:0] LAST_OP = OP_SWAP;
`else
  localparam logic [3:0] LAST_OP = OP_NOT;
`endif
  typedef enum logic [3:0] {
    IDLE, POP_A, POP_B, TOS_A, CAP_A, CAP_B, PUSH_R,
`ifdef STACK_SEQ_SWAP_EN
    PUSH_R2,
`endif
    DONE
  } state_t;
  state_t        state;
  logic [3:0]    op;
  logic [DW-1:0] imm, a, b;
  logic          accept, reject, binop, push2, peek;
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_ready = state == IDLE;
  assign done      = state == DONE;
`ifdef STACK_SEQ_SWAP_EN
  assign push2 = state == PUSH_R2;
`else
  assign push2 = 1'b0;
`endif
  assign stk_push = state == PUSH_R || push2;
  assign stk_pop  = state == POP_A || state == POP_B;
  assign stk_tos  = state == TOS_A;
  assign binop    = op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_SWAP;
  assign peek     = op == OP_POP || op == OP_TOS;
  // Depth is checked before any strobe so a rejected command never touches the stack
  assign reject = cmd_op > LAST_OP ? 1'b1 :
                  (cmd_op == OP_PUSH || cmd_op == OP_DUP) ? depth == DEPTH_W'(DEPTH) :
                  (cmd_op == OP_POP || cmd_op == OP_TOS || cmd_op == OP_NOT) ? depth == '0 :
                  depth < DEPTH_W'(2);
  // b is below a, so binary results are b op a; SWAP pushes a then b
  assign stk_in = push2 ? b :
                  op == OP_PUSH ? imm :
                  op == OP_NOT  ? ~a :
                  op == OP_ADD  ? b + a :
                  op == OP_SUB  ? b - a :
                  op == OP_AND  ? b & a : a;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      depth    <= '0;
      res_data <= '0;
      err      <= 1'b0;
      op       <= '0;
      imm      <= '0;
      a        <= '0;
      b        <= '0;
    end else begin
      depth <= stk_push ? depth + 1'b1 : stk_pop ? depth - 1'b1 : depth;
      case (state)
        IDLE: if (accept) begin
          op  <= cmd_op;
          imm <= cmd_data;
          err <= reject;
          if (reject) res_data <= '0;
          state <= reject ? DONE :
                   cmd_op == OP_PUSH ? PUSH_R :
                   (cmd_op == OP_TOS || cmd_op == OP_DUP) ? TOS_A : POP_A;
        end
        POP_A: state <= binop ? POP_B : CAP_A;
        POP_B: begin
          a     <= stk_out;
          state <= CAP_B;
        end
        CAP_B: begin
          b     <= stk_out;
          state <= PUSH_R;
        end
        TOS_A: state <= CAP_A;
        CAP_A: begin
          a <= stk_out;
          if (peek) res_data <= stk_out;
          state <= peek ? DONE : PUSH_R;
        end
`ifdef STACK_SEQ_SWAP_EN
        PUSH_R: begin
          if (op != OP_SWAP) res_data <= stk_in;
          state <= op == OP_SWAP ? PUSH_R2 : DONE;
        end
        PUSH_R2: begin
          res_data <= stk_in;
          state    <= DONE;
        end
`else
        PUSH_R: begin
          res_data <= stk_in;
          state    <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: scoreboard bench with a behavioural LIFO attached to the stack port.
// Honours STACK_SEQ_SWAP_EN the same way as the design.
module tb_stack_op_sequencer;
  localparam int DW = 8, DEPTH = 32, DEPTH_W = 6;
`ifdef STACK_SEQ_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif
  typedef logic [DW-1:0] byte_t;
  typedef struct {
    logic  e;
    byte_t r;
    int    d;
    int    c;
    int    np;
    int    nq;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [3:0] cmd_op = '0;
  byte_t cmd_data = '0;
  logic cmd_ready, done, err, stk_push, stk_pop, stk_tos;
  byte_t res_data, stk_in, stk_out;
  logic [DEPTH_W-1:0] depth;
  exp_t q[$];
  byte_t ref_q[$];
  byte_t mem [DEPTH];
  int sp, cyc = 0;
  int checks = 0, failures = 0;
  int push_cnt = 0, pop_cnt = 0, last_push = 0, last_pop = 0;
  int multi = 0, abuse = 0, done_cnt = 0, acc_mark = 0;
  byte_t last_res = '0;
  logic last_err = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  stack_op_sequencer #(.DW(DW), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .done(done), .err(err),
    .res_data(res_data), .depth(depth), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_tos(stk_tos), .stk_in(stk_in), .stk_out(stk_out)
  );
  // Registered-output LIFO: stk_out updates on the edge that samples pop/tos
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp      <= 0;
      stk_out <= '0;
    end else begin
      if (stk_push) begin
        if (sp < DEPTH) mem[sp] <= stk_in;
        sp <= sp + 1;
      end
      if (stk_pop) begin
        stk_out <= sp > 0 ? mem[sp-1] : '0;
        sp <= sp - 1;
      end
      if (stk_tos) stk_out <= sp > 0 ? mem[sp-1] : '0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic sample();
    exp_t x;
    if (rst) return;
    if (stk_push) push_cnt++;
    if (stk_pop) pop_cnt++;
    if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) multi++;
    if ((stk_push && sp >= DEPTH) || ((stk_pop || stk_tos) && sp == 0)) abuse++;
    if (done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        x = q.pop_front();
        chk("err", err, x.e);
        chk("res", res_data, x.r);
        chk("depth", depth, x.d);
        chk("cycles", cyc - acc_mark, x.c);
        chk("pushes", push_cnt - last_push, x.np);
        chk("pops", pop_cnt - last_pop, x.nq);
      end
      last_push = push_cnt;
      last_pop  = pop_cnt;
      last_res  = res_data;
      last_err  = err;
      done_cnt++;
    end
  endtask
  task automatic step();
    @(negedge clk);
    sample();
  endtask
  task automatic model(input logic [3:0] op, input byte_t d, output exp_t x);
    byte_t a, b;
    int n = ref_q.size();
    x = '{e: 1'b0, r: '0, d: 0, c: 1, np: 0, nq: 0};
    case (op)
      4'd0: if (n == DEPTH) x.e = 1'b1; else begin ref_q.push_back(d); x.r = d; x.c = 2; x.np = 1; end
      4'd1: if (n == 0) x.e = 1'b1; else begin x.r = ref_q.pop_back(); x.c = 3; x.nq = 1; end
      4'd2: if (n == 0) x.e = 1'b1; else begin x.r = ref_q[n-1]; x.c = 3; end
      4'd3: if (n == DEPTH || n == 0) x.e = 1'b1; else begin x.r = ref_q[n-1]; ref_q.push_back(x.r); x.c = 4; x.np = 1; end
      4'd7: if (n == 0) x.e = 1'b1; else begin x.r = ~ref_q.pop_back(); ref_q.push_back(x.r); x.c = 4; x.np = 1; x.nq = 1; end
      4'd4, 4'd5, 4'd6: if (n < 2) x.e = 1'b1; else begin
        a = ref_q.pop_back();
        b = ref_q.pop_back();
        x.r = op == 4'd4 ? byte_t'(b + a) : op == 4'd5 ? byte_t'(b - a) : b & a;
        ref_q.push_back(x.r);
        x.c = 5; x.np = 1; x.nq = 2;
      end
      4'd8: if (!SWAP_EN || n < 2) x.e = 1'b1; else begin
        a = ref_q.pop_back();
        b = ref_q.pop_back();
        ref_q.push_back(a);
        ref_q.push_back(b);
        x.r = b; x.c = 6; x.np = 2; x.nq = 2;
      end
      default: x.e = 1'b1;
    endcase
    if (x.e) begin x.r = '0; x.c = 1; x.np = 0; x.nq = 0; end
    x.d = ref_q.size();
  endtask
  task automatic send(input logic [3:0] op, input byte_t d);
    exp_t x;
    int n;
    model(op, d, x);
    q.push_back(x);
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    acc_mark = cyc;
    n = done_cnt;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && done_cnt == n; i++) step();
    if (done_cnt == n) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res", res_data, 0);
    chk("rst_depth", depth, 0);
    chk("rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
    rst = 1'b0;
    q.delete();
    ref_q.delete();
    last_push = push_cnt;
    last_pop  = pop_cnt;
  endtask
  initial begin
    do_reset();
    send(4'd0, 8'h05);
    send(4'd0, 8'h03);
    send(4'd5, 8'h00);
    chk("sub_res", last_res, 8'h02);
    chk("sub_depth", depth, 1);
    do_reset();
    send(4'd0, 8'hF0);
    send(4'd0, 8'h20);
    send(4'd4, 8'h00);
    chk("add_wrap", last_res, 8'h10);
    send(4'd3, 8'h00);
    send(4'd7, 8'h00);
    chk("not_res", last_res, 8'hEF);
    send(4'd1, 8'h00);
    send(4'd6, 8'h00);
    do_reset();
    send(4'd1, 8'h00);
    chk("underflow_err", last_err, 1);
    send(4'd0, 8'h07);
    send(4'd4, 8'h00);
    chk("add_short_err", last_err, 1);
    send(4'd12, 8'h00);
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(4'd0, byte_t'(i));
    chk("full_depth", depth, DEPTH);
    send(4'd0, 8'h55);
    chk("overflow_err", last_err, 1);
    send(4'd3, 8'h00);
    send(4'd2, 8'h00);
    chk("tos_full", last_res, 31);
    for (int i = 0; i < DEPTH; i++) send(4'd1, 8'h00);
    do_reset();
    send(4'd0, 8'hAA);
    send(4'd0, 8'hBB);
    send(4'd8, 8'h00);
    send(4'd1, 8'h00);
    send(4'd1, 8'h00);
    do_reset();
    send(4'd0, 8'h11);
    send(4'd0, 8'h22);
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    cmd_op = 4'd4; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("popa_strobe", stk_pop, 1);
    @(posedge clk);
    #1;
    chk("popb_strobe", stk_pop, 1);
    chk("popb_busy", cmd_ready, 0);
    rst = 1'b1;
    #1;
    chk("midrst_idle", cmd_ready, 1);
    chk("midrst_depth", depth, 0);
    chk("midrst_done", done, 0);
    step();
    chk("midrst_hold", {cmd_ready, done, depth}, {1'b1, 1'b0, 6'd0});
    rst = 1'b0;
    q.delete();
    ref_q.delete();
    last_push = push_cnt;
    last_pop  = pop_cnt;
    send(4'd0, 8'h01);
    send(4'd1, 8'h00);
    chk("post_rst_pop", last_res, 8'h01);
    chk("one_strobe", multi, 0);
    chk("stack_abuse", abuse, 0);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
